free_man_picker: RTL

- Sequential selector feeding the stable-match one-hot-to-binary encoder stage.
- Holds a mask of currently free proposers and issues one proposer per handshake as a one-hot grant vector. The downstream encoder converts that vector to an index.
- Accepts "rejected/released" indices back from the matching core so that proposer re-enters the pool. Asserts done when no free proposer remains.

---
 rtl/free_man_picker.sv | 119 +++++++++++
 1 files changed

// File: rtl/free_man_picker.sv
// free_man_picker: hands out free proposers one at a time as one-hot grants, takes released proposers back, and flags done when none are left (FREE_PICK_RR_EN selects round-robin priority)
module free_man_picker #(
    parameter int logS = 4,
    parameter int CNT_W = 16,
    localparam int S = 2 ** logS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [S-1:0]     free_in,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [S-1:0]     grant_onehot,
    input  logic             release_valid,
    input  logic [logS-1:0]  release_idx,
    output logic             done,
    output logic [CNT_W-1:0] grant_cnt
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;
    localparam logic [S-1:0] ONE = 1;
    state_t state, state_n;
    logic [S-1:0] f, f_n, g, g_n, rel;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [logS-1:0] base, sel;
    logic xfer, reload;
    function automatic logic [logS-1:0] pick(input logic [S-1:0] v, input logic [logS-1:0] b);
        logic [logS-1:0] r, idx;
        r = b;
        for (int k = S - 1; k >= 0; k--) begin
            idx = b + logS'(k);
            if (v[idx]) r = idx;
        end
        return r;
    endfunction
    assign xfer = (state == HOLD) && grant_ready;
    assign reload = ((state == IDLE) || (state == DONE)) && load;
    assign rel = release_valid ? (ONE << release_idx) : '0;
    assign sel = pick(f, base);
    assign grant_valid = (state == HOLD);
    assign grant_onehot = g;
    assign done = (state == DONE);
    assign grant_cnt = cnt;
`ifdef FREE_PICK_RR_EN
    logic [logS-1:0] p;
    function automatic logic [logS-1:0] enc(input logic [S-1:0] v);
        logic [logS-1:0] r;
        r = '0;
        for (int i = 0; i < S; i++)
            if (v[i]) r = logS'(i);
        return r;
    endfunction
    // round-robin pointer: restart at 0 on reload, move past each accepted grant
    always_ff @(posedge clk) begin
        if (rst) p <= '0;
        else if (reload) p <= '0;
        else if (xfer) p <= enc(g) + 1'b1;
    end
    assign base = p;
`else
    assign base = '0;
`endif
    // next-state logic: scanning, holding the grant, releases folded into the free mask
    always_comb begin
        state_n = state;
        f_n = f;
        g_n = g;
        cnt_n = cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    f_n = free_in;
                    cnt_n = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                f_n = f | rel;
                if (f == '0) state_n = release_valid ? SCAN : DONE;
                else begin
                    g_n = ONE << sel;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                f_n = f | rel;
                if (grant_ready) begin
                    f_n = (f & ~g) | rel;
                    g_n = '0;
                    cnt_n = (&cnt) ? cnt : cnt + 1'b1;
                    state_n = SCAN;
                end
            end
            default: begin
                if (load) begin
                    f_n = free_in;
                    cnt_n = '0;
                    state_n = SCAN;
                end else if (release_valid) begin
                    f_n = f | rel;
                    state_n = SCAN;
                end
            end
        endcase
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            f <= '0;
            g <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            f <= f_n;
            g <= g_n;
            cnt <= cnt_n;
        end
    end
endmodule
